// File: rtl/conv_fft_pkg.sv
// Shared types and constants for the convolution FFT buffer.
package conv_fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Real part in the low half so a packed complex maps onto word order re, im
  typedef struct packed {
    logic signed [31:0] im;
    logic signed [31:0] re;
  } cplx_t;

  localparam int BEATS_FULL = 8;
  localparam int BEATS_REAL = 4;
  localparam int ENTRY_W    = 1024;

  // Multiply by (-j)^q; the only twiddles a 4-point DFT needs
  function automatic cplx_t rot_mj(input cplx_t c, input logic [1:0] q);
    cplx_t r;
    unique case (q)
      2'd0: r = c;
      2'd1: begin r.re = c.im;  r.im = -c.re; end
      2'd2: begin r.re = -c.re; r.im = -c.im; end
      default: begin r.re = -c.im; r.im = c.re; end
    endcase
    return r;
  endfunction

  function automatic cplx_t cadd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

endpackage

// File: rtl/conv_fft_lane.sv
// One tile lane: builds the 4x4 input patch, transforms it and stores the result.
module conv_fft_lane
  import conv_fft_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic [127:0]       words,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0]  raddr,
  output logic               next_out,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] x_in;
  logic [ENTRY_W-1:0] y_out;

  // Real 2x2 patch in the top-left corner of an otherwise zero grid
  always_comb begin
    x_in = '0;
    x_in[0*64 +: 32] = words[31:0];
    x_in[1*64 +: 32] = words[63:32];
    x_in[4*64 +: 32] = words[95:64];
    x_in[5*64 +: 32] = words[127:96];
  end

  fft4_2d u_fft (
    .clk      (clk),
    .reset    (reset),
    .next     (next),
    .x        (x_in),
    .next_out (next_out),
    .y        (y_out)
  );

  memBlockImage #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (y_out),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: rtl/fft4_2d.sv
// 4x4 2-D DFT; data follows next by one cycle, result follows next_out by one cycle.
module fft4_2d
  import conv_fft_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic [ENTRY_W-1:0] x,
  output logic               next_out,
  output logic [ENTRY_W-1:0] y
);

  logic               vld_p0;
  logic [ENTRY_W-1:0] y_p1;

  // Row transforms then column transforms, wrapping 32-bit arithmetic
  function automatic logic [ENTRY_W-1:0] dft2d(input logic [ENTRY_W-1:0] xin);
    cplx_t              a [4][4];
    cplx_t              b [4][4];
    cplx_t              acc;
    logic [ENTRY_W-1:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) a[i/4][i%4] = xin[64*i +: 64];
    for (int r = 0; r < 4; r++)
      for (int k2 = 0; k2 < 4; k2++) begin
        acc = '0;
        for (int n2 = 0; n2 < 4; n2++) acc = cadd(acc, rot_mj(a[r][n2], 2'((n2 * k2) % 4)));
        b[r][k2] = acc;
      end
    for (int k1 = 0; k1 < 4; k1++)
      for (int k2 = 0; k2 < 4; k2++) begin
        acc = '0;
        for (int n1 = 0; n1 < 4; n1++) acc = cadd(acc, rot_mj(b[n1][k2], 2'((n1 * k1) % 4)));
        res[64*(4*k1+k2) +: 64] = acc;
      end
    return res;
  endfunction

  // Stage p0: the cycle carrying input data
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= next;
  end

  // Stage p1: transform result held until the next job overwrites it
  always_ff @(posedge clk) begin
    if (vld_p0) y_p1 <= dft2d(x);
  end

  assign next_out = vld_p0;
  assign y        = y_p1;

endmodule

// File: rtl/mem_block_image.sv
// Simple dual-port image memory with a one-cycle registered read.
module memBlockImage #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_fft_buffer.sv
// Job controller: fills per-lane FFT buffers, then drains them as output beats.
module conv_fft_buffer
  import conv_fft_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int ADDR_W    = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W:0]          ctx_length,
  input  logic                     out_mode,
  input  logic                     input_valid,
  input  logic [128*NUM_TILES-1:0] cacheline_in,
  input  logic                     output_fifo_full,
  output logic                     output_valid,
  output logic [128*NUM_TILES-1:0] cacheline_out,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_C = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t               state, state_nx;
  logic [ADDR_W:0]      len_r, in_cnt, wr_cnt, ent_cnt;
  logic [ADDR_W-1:0]    wr_addr, rd_addr;
  logic [2:0]           beat, beat_p1;
  logic                 mode_r, wr_pend_p0, vld_p1, error_r, done_r;
  logic                 start_ok, start_bad, accept, in_bad, wr_en, issue, last_beat;
  logic                 fill_end, drain_end;
  logic [NUM_TILES-1:0] lane_nxt;
  logic [ENTRY_W-1:0]   lane_rdata [NUM_TILES];

  function automatic int word_sel(input logic m, input logic [2:0] b, input int j);
    return m ? 2 * (4 * int'(b) + j) : 4 * int'(b) + j;
  endfunction

  assign start_ok  = start && (state == IDLE) && (ctx_length != '0) && (ctx_length <= DEPTH);
  assign start_bad = start && (state == IDLE) && !start_ok;
  assign accept    = input_valid && (state == FILL) && (in_cnt != len_r);
  assign in_bad    = input_valid && !accept;
  assign wr_en     = wr_pend_p0 && (state == FILL);
  assign fill_end  = wr_en && ((wr_cnt + ONE_C) == len_r);
  assign last_beat = mode_r ? (beat == 3'(BEATS_REAL - 1)) : (beat == 3'(BEATS_FULL - 1));
  assign issue     = (state == DRAIN) && !output_fifo_full;
  assign drain_end = issue && last_beat && (ent_cnt == (len_r - ONE_C));

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_lane
    conv_fft_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .next     (accept),
      .words    (cacheline_in[128*t +: 128]),
      .we       (wr_en),
      .waddr    (wr_addr),
      .raddr    (rd_addr),
      .next_out (lane_nxt[t]),
      .rdata    (lane_rdata[t])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok)  state_nx = FILL;
      FILL:    if (fill_end)  state_nx = DRAIN;
      DRAIN:   if (drain_end) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end

  // Job parameters, fill/drain counters and addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r   <= '0;
      mode_r  <= 1'b0;
      in_cnt  <= '0;
      wr_cnt  <= '0;
      wr_addr <= '0;
      ent_cnt <= '0;
      rd_addr <= '0;
      beat    <= '0;
    end else if (start_ok) begin
      len_r   <= ctx_length;
      mode_r  <= out_mode;
      in_cnt  <= '0;
      wr_cnt  <= '0;
      wr_addr <= '0;
      ent_cnt <= '0;
      rd_addr <= '0;
      beat    <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + ONE_C;
      if (wr_en) begin
        wr_cnt  <= wr_cnt + ONE_C;
        wr_addr <= wr_addr + ONE_A;
      end
      if (issue) begin
        if (last_beat) begin
          beat    <= '0;
          rd_addr <= rd_addr + ONE_A;
          ent_cnt <= ent_cnt + ONE_C;
        end else begin
          beat <= beat + 3'd1;
        end
      end
    end
  end

  // Write strobe, sticky error and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend_p0 <= 1'b0;
      error_r    <= 1'b0;
      done_r     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      wr_pend_p0 <= &lane_nxt;
      error_r    <= (error_r && !start_ok) || start_bad || in_bad;
      done_r     <= (state == FINISH);
      vld_p1     <= issue;
    end
  end

  // Stage p1: beat select travels with the memory read
  always_ff @(posedge clk) begin
    beat_p1 <= beat;
  end

  // Beat mux over registered read data; zero whenever no beat is valid
  always_comb begin
    cacheline_out = '0;
    if (vld_p1) begin
      for (int t = 0; t < NUM_TILES; t++)
        for (int j = 0; j < 4; j++)
          cacheline_out[128*t + 32*j +: 32] = lane_rdata[t][32*word_sel(mode_r, beat_p1, j) +: 32];
    end
  end

  assign output_valid = vld_p1;
  assign busy         = (state != IDLE);
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: doc/conv_fft_buffer.md
CONV_FFT_BUFFER -- requirements
Module: conv_fft_buffer

Interface
REQ-001 Parameter NUM_TILES, default 4; number of parallel 4x4 2-D FFT lanes; cacheline width CL_W = 128*NUM_TILES.
REQ-002 Parameter ADDR_W, default 13; buffer depth DEPTH = 2**ADDR_W entries per lane.
REQ-003 clk  input  1  single clock; reset  input  1  synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a job when in IDLE.
REQ-005 ctx_length  input  ADDR_W+1  number of input cachelines in the job; sampled on start.
REQ-006 out_mode  input  1  0 = full complex readout, 1 = real-only readout; sampled on start.
REQ-007 input_valid  input  1  marks cacheline_in valid on the following cycle.
REQ-008 cacheline_in  input  CL_W  lane t owns bits [128t+127:128t] as four 32-bit words w0..w3.
REQ-009 output_fifo_full  input  1  downstream almost-full; at least 2 free slots remain while low.
REQ-010 output_valid  output  1  registered; cacheline_out valid this cycle.
REQ-011 cacheline_out  output  CL_W  registered output beat.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after the final beat of a job.
REQ-014 error  output  1  sticky; cleared only by reset or by a legal start.

Function
REQ-015 FSM states IDLE, FILL, DRAIN, FINISH; only transitions listed here are legal.
REQ-016 IDLE->FILL on start with 1 <= ctx_length <= DEPTH; counters and addresses cleared, error cleared.
REQ-017 Start with ctx_length 0 or > DEPTH sets error and remains in IDLE.
REQ-018 Each lane's 4x4 input: row0 = {w0,w1,0,0}, row1 = {w2,w3,0,0}, rows 2-3 zero, imaginary parts zero.
REQ-019 In FILL, input_valid drives all lane FFT next inputs; each write is one entry at write_address, incremented modulo DEPTH.
REQ-020 A write happens on the cycle after the AND of all lanes' next_out; the write count is compared against latched ctx_length.
REQ-021 FILL->DRAIN on the cycle the write count reaches ctx_length.
REQ-022 input_valid outside FILL, or arriving after ctx_length writes, is ignored and sets error.
REQ-023 Entry word order per lane: k = 2*(4*row+col)+p, p = 0 real, p = 1 imag; 32 words.
REQ-024 Mode 0: 8 beats per entry; beat b carries words 4b..4b+3 of lane t at bits [128t+32j+31:128t+32j], j = 0..3.
REQ-025 Mode 1: 4 beats per entry; beat b carries the real parts of row b, columns 0..3, same lane placement.
REQ-026 DRAIN issues one memory read per cycle while output_fifo_full is low; no read issues in a cycle where it is high.
REQ-027 Memory read latency is 1 cycle; output_valid rises 1 cycle after issue; an in-flight beat always completes.
REQ-028 Beat counter wraps to 0 per entry and the read address advances; after the last beat of entry ctx_length-1, DRAIN->FINISH.
REQ-029 FINISH pulses done for one cycle, then goes to IDLE; start is ignored in any non-IDLE state.
REQ-030 No arithmetic beyond counters; FFT precision and scaling are defined by the lane FFT.

Reset
REQ-031 Reset forces IDLE; output_valid, done, busy and error are 0, cacheline_out is 0, and all counters and addresses are 0.
REQ-032 Reset mid-job abandons the job; in-flight FFT outputs arriving after reset are not written.

Structure
REQ-033 Package conv_fft_pkg holds the state enum, a 32-bit complex typedef, and the constants BEATS_FULL=8 and BEATS_REAL=4.
REQ-034 Sub-module conv_fft_lane instantiates one fft4_2d and one memBlockImage; it is replicated NUM_TILES times.
REQ-035 The FSM, counters and beat mux live in conv_fft_buffer.

Verification
REQ-036 NUM_TILES=4, ctx_length=3, mode 0, 3 inputs, fifo never full -> 24 beats, then done; beat order matches REQ-024 against the golden FFT.
REQ-037 Same job in mode 1 -> 12 beats, each holding real parts only; done one cycle after the last output_valid.
REQ-038 Mode 0, output_fifo_full held high for 5 cycles mid-DRAIN -> no beats lost or duplicated; 24 total.
REQ-039 start with ctx_length=0 -> error=1, busy=0; next start with ctx_length=1 -> error clears and the job completes.
REQ-040 Reset asserted during FILL after 2 of 4 inputs -> IDLE, outputs 0; a fresh job of 2 runs cleanly.
REQ-041 A 5th input_valid on a ctx_length=4 job -> error=1, the extra line is not stored, and 32 beats are still produced.
